// File: rtl/gauss_series_pkg.sv
// Shared mode encodings and FSM state type for the iterative series unit.
package gauss_series_pkg;

   localparam logic [1:0] MODE_TRI = 2'b00;
   localparam logic [1:0] MODE_SQR = 2'b01;
   localparam logic [1:0] MODE_MUL = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gauss_series_term.sv
// Combinational term generator: selects the value added in each RUN cycle.
module gauss_series_term
   import gauss_series_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] term,
   output logic             sq_ovf
);

   logic [2*WIDTH-1:0] prod;

   always_comb begin
      prod   = {{WIDTH{1'b0}}, cnt} * {{WIDTH{1'b0}}, cnt};
      term   = '0;
      sq_ovf = 1'b0;
      case (mode)
         MODE_TRI: term = cnt;
         MODE_SQR: begin
            term   = prod[WIDTH-1:0];
            sq_ovf = |prod[2*WIDTH-1:WIDTH];
         end
         MODE_MUL: term = a;
         default:  term = '0;
      endcase
   end

endmodule

// File: rtl/gauss_series_unit.sv
// Multi-cycle series unit: one term per cycle, results returned with tag
// and sticky overflow/error flags over a backpressured port.
module gauss_series_unit
   import gauss_series_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             preset,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [1:0]       issue_mode,
   input  logic [WIDTH-1:0] issue_n,
   input  logic [WIDTH-1:0] issue_a,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             busy,
   output logic             last,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] result_tag,
   output logic             result_ovf,
   output logic             result_err
);

   state_t           state;
   logic [1:0]       mode;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] acum;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] term;
   logic             sq_ovf;
   logic [WIDTH:0]   sum;
   logic             cnt_one;

   gauss_series_term #(.WIDTH(WIDTH)) u_term (
      .mode   (mode),
      .cnt    (cnt),
      .a      (a),
      .term   (term),
      .sq_ovf (sq_ovf)
   );

   assign sum          = {1'b0, acum} + {1'b0, term};
   assign cnt_one      = (cnt == WIDTH'(1));
   assign issue_ready  = (state == IDLE) & ~flush & ~preset;
   assign busy         = (state == RUN);
   assign last         = (state == RUN) & cnt_one;
   assign result_valid = (state == DONE);
   assign result       = acum;

   always_ff @(posedge clk) begin
      if (preset) begin
         state      <= IDLE;
         mode       <= MODE_TRI;
         cnt        <= '0;
         acum       <= '0;
         a          <= '0;
         result_tag <= '0;
         result_ovf <= 1'b0;
         result_err <= 1'b0;
      end else if (flush && state != IDLE) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (issue_valid && issue_ready) begin
                  mode       <= issue_mode;
                  a          <= issue_a;
                  result_tag <= issue_tag;
                  cnt        <= issue_n;
                  acum       <= '0;
                  result_ovf <= 1'b0;
                  result_err <= (issue_mode == MODE_RSV);
                  // empty or reserved jobs skip RUN and return zero
                  if (issue_n == '0 || issue_mode == MODE_RSV)
                     state <= DONE;
                  else
                     state <= RUN;
               end
            end
            RUN: begin
               acum <= sum[WIDTH-1:0];
               cnt  <= cnt - WIDTH'(1);
               if (sum[WIDTH] || sq_ovf)
                  result_ovf <= 1'b1;
               if (cnt_one)
                  state <= DONE;
            end
            DONE: begin
               if (result_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gauss_series_unit.sv
// Scoreboard bench for gauss_series_unit: driver queues expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_gauss_series_unit;

   localparam int W = 16;
   localparam int T = 4;

   logic         clk;
   logic         preset;
   logic         flush;
   logic         issue_valid;
   logic         issue_ready;
   logic [1:0]   issue_mode;
   logic [W-1:0] issue_n;
   logic [W-1:0] issue_a;
   logic [T-1:0] issue_tag;
   logic         busy;
   logic         last;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] result;
   logic [T-1:0] result_tag;
   logic         result_ovf;
   logic         result_err;

   gauss_series_unit #(.WIDTH(W), .TAG_W(T)) dut (
      .clk          (clk),
      .preset       (preset),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_mode   (issue_mode),
      .issue_n      (issue_n),
      .issue_a      (issue_a),
      .issue_tag    (issue_tag),
      .busy         (busy),
      .last         (last),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .result_tag   (result_tag),
      .result_ovf   (result_ovf),
      .result_err   (result_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [T-1:0] tag;
      logic         ovf;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every accepted result must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (!preset && result_valid && result_ready) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_result: got tag %0d, expected none",
                     result_tag);
         end else begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("result_tag", 32'(result_tag), 32'(e.tag));
            check("result_ovf", 32'(result_ovf), 32'(e.ovf));
            check("result_err", 32'(result_err), 32'(e.err));
         end
      end
   end

   task automatic issue(input logic [1:0] m, input logic [W-1:0] n,
                        input logic [W-1:0] av, input logic [T-1:0] tg,
                        output bit ok);
      ok          = 1'b0;
      issue_valid = 1'b1;
      issue_mode  = m;
      issue_n     = n;
      issue_a     = av;
      issue_tag   = tg;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (issue_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      issue_valid = 1'b0;
      if (!ok) check("issue_timeout", 32'd0, 32'd1);
   endtask

   // Issue a job, queue its expectation, and measure latency and last pulses
   task automatic run_job(input logic [1:0] m, input logic [W-1:0] n,
                          input logic [W-1:0] av, input logic [T-1:0] tg,
                          input logic [W-1:0] er, input logic eo,
                          input logic ee, input int lat, input int lasts);
      bit ok;
      int cyc;
      int lc;
      bit seen;
      issue(m, n, av, tg, ok);
      if (ok) begin
         sb.push_back('{res: er, tag: tg, ovf: eo, err: ee});
         cyc  = 0;
         lc   = 0;
         seen = 1'b0;
         while (!seen && cyc < lat + 20) begin
            @(negedge clk);
            cyc++;
            if (last) lc++;
            if (result_valid) seen = 1'b1;
         end
         if (!seen) check("result_timeout", 32'd0, 32'd1);
         check("latency", 32'(cyc), 32'(lat));
         check("last_pulses", 32'(lc), 32'(lasts));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int seen;
      preset       = 1'b1;
      flush        = 1'b0;
      issue_valid  = 1'b0;
      issue_mode   = 2'b00;
      issue_n      = '0;
      issue_a      = '0;
      issue_tag    = '0;
      result_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_issue_ready", 32'(issue_ready), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      @(posedge clk);
      #1;
      preset = 1'b0;
      @(negedge clk);
      check("idle_issue_ready", 32'(issue_ready), 32'd1);
      @(posedge clk);
      #1;

      // Main function, tags 3, 5, 9 in order
      run_job(2'b00, 16'd4, 16'd0, 4'd3, 16'd10, 1'b0, 1'b0, 5, 1);
      run_job(2'b01, 16'd3, 16'd0, 4'd5, 16'd14, 1'b0, 1'b0, 4, 1);
      run_job(2'b10, 16'd5, 16'd7, 4'd9, 16'd35, 1'b0, 1'b0, 6, 1);
      run_job(2'b00, 16'd0, 16'd0, 4'd1, 16'd0, 1'b0, 1'b0, 1, 0);
      run_job(2'b11, 16'd5, 16'd3, 4'd2, 16'd0, 1'b0, 1'b1, 1, 0);
      // 80200 mod 65536 = 14664
      run_job(2'b00, 16'd400, 16'd0, 4'd11, 16'd14664, 1'b1, 1'b0, 401, 1);
      // 9045050 mod 65536 = 1082; 256*256 overflows the square
      run_job(2'b01, 16'd300, 16'd0, 4'd12, 16'd1082, 1'b1, 1'b0, 301, 1);

      // Backpressure: TRI n=5 tag 6 held for 10 cycles
      result_ready = 1'b0;
      issue(2'b00, 16'd5, 16'd0, 4'd6, ok);
      if (ok) begin
         sb.push_back('{res: 16'd15, tag: 4'd6, ovf: 1'b0, err: 1'b0});
         seen = 0;
         for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
         end
         check("bp_valid", 32'(seen), 32'd1);
         for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            issue_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_valid", 32'(result_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'd15);
            check("bp_hold_tag", 32'(result_tag), 32'd6);
            check("bp_hold_flags", 32'({result_ovf, result_err}), 32'd0);
            check("bp_issue_ready", 32'(issue_ready), 32'd0);
         end
         @(posedge clk);
         #1;
         issue_valid  = 1'b0;
         result_ready = 1'b1;
         @(negedge clk);
         @(posedge clk);
         #1;
      end

      // Flush during RUN of TRI n=8
      issue(2'b00, 16'd8, 16'd0, 4'd2, ok);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_busy_before", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_valid", 32'(result_valid), 32'd0);
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_issue_ready", 32'(issue_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      check("flush_no_result", 32'(seen), 32'd0);
      @(posedge clk);
      #1;
      run_job(2'b00, 16'd6, 16'd0, 4'd4, 16'd21, 1'b0, 1'b0, 7, 1);

      // Preset in the middle of SQR n=10
      issue(2'b01, 16'd10, 16'd0, 4'd7, ok);
      repeat (3) @(posedge clk);
      #1;
      preset = 1'b1;
      @(negedge clk);
      check("preset_issue_ready", 32'(issue_ready), 32'd0);
      @(posedge clk);
      #1;
      preset = 1'b0;
      @(negedge clk);
      check("preset_result", 32'(result), 32'd0);
      check("preset_tag", 32'(result_tag), 32'd0);
      check("preset_flags", 32'({result_ovf, result_err}), 32'd0);
      check("preset_ctrl", 32'({busy, last, result_valid}), 32'd0);
      check("preset_ready", 32'(issue_ready), 32'd1);
      @(posedge clk);
      #1;

      // flush with issue_valid in IDLE: job must not be taken
      flush       = 1'b1;
      issue_valid = 1'b1;
      issue_mode  = 2'b00;
      issue_n     = 16'd3;
      issue_tag   = 4'd1;
      @(negedge clk);
      check("flush_idle_ready", 32'(issue_ready), 32'd0);
      @(posedge clk);
      #1;
      flush       = 1'b0;
      issue_valid = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", 32'({busy, result_valid}), 32'd0);
      @(posedge clk);
      #1;

      run_job(2'b10, 16'd3, 16'd100, 4'd8, 16'd300, 1'b0, 1'b0, 4, 1);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
